// File: rtl/instruction_sequencer.sv
// Micro-instruction sequencer: accepts packed instructions over valid/ready and
// issues registered write strobes, go pulses, error pulses and read bursts.
module instruction_sequencer #(
  parameter  int FIELD_W = 15,
  localparam int INSTR_W = 2 + 2 * FIELD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic               wr_en,
  output logic [FIELD_W-1:0] wr_addr,
  output logic [FIELD_W-1:0] wr_data,
  output logic               rd_en,
  input  logic               rd_ready,
  output logic [FIELD_W-1:0] rd_addr,
  output logic               rd_last,
  output logic               go,
  output logic               busy,
  output logic               err
);

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_GO    = 2'b10,
    OP_RSVD  = 2'b11
  } opcode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Handshakes: an instruction transfers on a cycle with instr_valid && instr_ready;
  // a read beat transfers on a cycle with rd_en && rd_ready, and rd_en holds until then.

  state_t               state_q, state_d;
  logic                 wr_en_q, wr_en_d;
  logic [FIELD_W-1:0]   wr_addr_q, wr_addr_d;
  logic [FIELD_W-1:0]   wr_data_q, wr_data_d;
  logic                 go_q, go_d;
  logic                 err_q, err_d;
  logic [FIELD_W-1:0]   rd_addr_q, rd_addr_d;
  logic [FIELD_W-1:0]   end_q, end_d;
  logic                 rd_last_q, rd_last_d;

  opcode_t              opcode;
  logic [FIELD_W-1:0]   field_a;
  logic [FIELD_W-1:0]   field_b;
  logic                 accept;
  logic [FIELD_W-1:0]   rd_addr_inc;

  assign opcode      = opcode_t'(instr[INSTR_W-1:INSTR_W-2]);
  assign field_a     = instr[2*FIELD_W-1:FIELD_W];
  assign field_b     = instr[FIELD_W-1:0];
  assign instr_ready = (state_q == IDLE);
  assign accept      = instr_valid && instr_ready;
  assign rd_addr_inc = rd_addr_q + FIELD_W'(1);

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    go_d      = 1'b0;
    err_d     = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    end_d     = end_q;
    rd_last_d = rd_last_q;

    case (state_q)
      IDLE: begin
        rd_last_d = 1'b0;
        if (accept) begin
          case (opcode)
            OP_WRITE: begin
              wr_en_d   = 1'b1;
              wr_addr_d = field_a;
              wr_data_d = field_b;
            end
            OP_READ: begin
              if (field_b >= field_a) begin
                state_d   = BURST;
                rd_addr_d = field_a;
                end_d     = field_b;
                rd_last_d = (field_a == field_b);
              end else begin
                err_d = 1'b1;
              end
            end
            OP_GO:   go_d  = 1'b1;
            default: err_d = 1'b1;
          endcase
        end
      end
      BURST: begin
        // End is found by equality, so a burst ending at the top address never wraps.
        if (rd_ready) begin
          if (rd_last_q) begin
            state_d   = IDLE;
            rd_last_d = 1'b0;
          end else begin
            rd_addr_d = rd_addr_inc;
            rd_last_d = (rd_addr_inc == end_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      go_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_addr_q <= '0;
      end_q     <= '0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      go_q      <= go_d;
      err_q     <= err_d;
      rd_addr_q <= rd_addr_d;
      end_q     <= end_d;
      rd_last_q <= rd_last_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign go      = go_q;
  assign err     = err_q;
  assign rd_addr = rd_addr_q;
  assign rd_last = rd_last_q;
  assign rd_en   = (state_q == BURST);
  assign busy    = (state_q == BURST);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: directed vector table, hand-written corner
// sequences and randomized instructions checked against a transaction model.
module tb_instruction_sequencer;

  localparam int FW = 15;
  localparam int IW = 2 + 2 * FW;

  logic          clk;
  logic          rst;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          wr_en;
  logic [FW-1:0] wr_addr;
  logic [FW-1:0] wr_data;
  logic          rd_en;
  logic          rd_ready;
  logic [FW-1:0] rd_addr;
  logic          rd_last;
  logic          go;
  logic          busy;
  logic          err;

  int checks   = 0;
  int failures = 0;

  // Last written address/data as seen by the model.
  int model_wa = 0;
  int model_wd = 0;

  instruction_sequencer #(.FIELD_W(FW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_last(rd_last), .go(go), .busy(busy), .err(err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_quiet_strobes(input string tag);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_go"},    int'(go),    0);
    chk({tag, "_err"},   int'(err),   0);
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge; returns at the next negedge, where the instruction's
  // one-cycle-later outputs are visible.
  task automatic send(input logic [1:0] op, input int a, input int b);
    logic [FW-1:0] fa;
    logic [FW-1:0] fb;
    fa = FW'(a);
    fb = FW'(b);
    instr       = {op, fa, fb};
    instr_valid = 1'b1;
    chk("instr_ready_at_send", int'(instr_ready), 1);
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = '0;
  endtask

  // Drains a burst s..e starting at the cycle its first beat is visible.
  // mode 0: always ready; 1: random stalls; 2: two stall cycles at s+1.
  task automatic run_burst(input int s, input int e, input int mode);
    int exp_addr;
    int accepted;
    int cycles;
    int stalls;
    int held4;
    exp_addr = s;
    accepted = 0;
    cycles   = 0;
    stalls   = 0;
    held4    = 0;
    while (accepted < e - s + 1 && cycles < 400) begin
      chk("burst_rd_en",       int'(rd_en),       1);
      chk("burst_busy",        int'(busy),        1);
      chk("burst_instr_ready", int'(instr_ready), 0);
      chk("burst_rd_addr",     int'(rd_addr),     exp_addr);
      chk("burst_rd_last",     int'(rd_last),     (exp_addr == e) ? 1 : 0);
      chk_quiet_strobes("burst");
      if (exp_addr == s + 1) held4++;
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ($urandom_range(0, 3) != 0);
        default: begin
          rd_ready = !(exp_addr == s + 1 && stalls < 2);
          if (!rd_ready) stalls++;
        end
      endcase
      @(negedge clk);
      cycles++;
      if (rd_ready) begin
        accepted++;
        exp_addr++;
      end
    end
    chk("burst_beats", accepted, e - s + 1);
    if (mode == 2) chk("burst_stall_hold_cycles", held4, 3);
    chk("after_burst_rd_en",       int'(rd_en),       0);
    chk("after_burst_busy",        int'(busy),        0);
    chk("after_burst_rd_last",     int'(rd_last),     0);
    chk("after_burst_instr_ready", int'(instr_ready), 1);
    chk("after_burst_rd_addr_hold", int'(rd_addr),    e);
  endtask

  // Checks the cycle after a non-burst instruction using the model's rules.
  task automatic check_single(input logic [1:0] op, input int a, input int b);
    int ew;
    int eg;
    int ee;
    ew = (op == 2'b00) ? 1 : 0;
    eg = (op == 2'b10) ? 1 : 0;
    ee = (op == 2'b11 || (op == 2'b01 && b < a)) ? 1 : 0;
    if (ew == 1) begin
      model_wa = a;
      model_wd = b;
    end
    chk("single_wr_en",   int'(wr_en),   ew);
    chk("single_go",      int'(go),      eg);
    chk("single_err",     int'(err),     ee);
    chk("single_wr_addr", int'(wr_addr), model_wa);
    chk("single_wr_data", int'(wr_data), model_wd);
    chk("single_rd_en",   int'(rd_en),   0);
    chk("single_ready",   int'(instr_ready), 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] op;
    int         a;
    int         b;
    logic       exp_wr;
    logic       exp_go;
    logic       exp_err;
    int         exp_beats;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int s;
    int e;
    int op_i;

    vecs[0] = '{2'b00, 'h0012, 'h7ABC, 1'b1, 1'b0, 1'b0, 0};
    vecs[1] = '{2'b10, 'h1234, 'h0567, 1'b0, 1'b1, 1'b0, 0};
    vecs[2] = '{2'b11, 'h0055, 'h0066, 1'b0, 1'b0, 1'b1, 0};
    vecs[3] = '{2'b01, 3,      5,      1'b0, 1'b0, 1'b0, 3};
    vecs[4] = '{2'b01, 'h7FFE, 'h7FFF, 1'b0, 1'b0, 1'b0, 2};
    vecs[5] = '{2'b01, 9,      9,      1'b0, 1'b0, 1'b0, 1};
    vecs[6] = '{2'b01, 5,      2,      1'b0, 1'b0, 1'b1, 0};
    vecs[7] = '{2'b00, 'h7FFF, 'h0000, 1'b1, 1'b0, 1'b0, 0};

    rst         = 1'b1;
    instr       = '0;
    instr_valid = 1'b0;
    rd_ready    = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_wr_en",   int'(wr_en),   0);
    chk("reset_go",      int'(go),      0);
    chk("reset_err",     int'(err),     0);
    chk("reset_rd_en",   int'(rd_en),   0);
    chk("reset_busy",    int'(busy),    0);
    chk("reset_rd_addr", int'(rd_addr), 0);
    chk("reset_rd_last", int'(rd_last), 0);
    chk("reset_wr_addr", int'(wr_addr), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", int'(instr_ready), 1);

    // Table-driven single instructions.
    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      chk("vec_wr_en", int'(wr_en), int'(vecs[i].exp_wr));
      chk("vec_go",    int'(go),    int'(vecs[i].exp_go));
      chk("vec_err",   int'(err),   int'(vecs[i].exp_err));
      if (vecs[i].exp_wr) begin
        model_wa = vecs[i].a;
        model_wd = vecs[i].b;
      end
      if (vecs[i].exp_beats > 0) begin
        chk("vec_first_rd_en", int'(rd_en), 1);
        run_burst(vecs[i].a, vecs[i].b, 0);
      end else begin
        chk("vec_rd_en",   int'(rd_en),   0);
        chk("vec_wr_addr", int'(wr_addr), model_wa);
        chk("vec_wr_data", int'(wr_data), model_wd);
        @(negedge clk);
        chk_quiet_strobes("vec_pulse_end");
      end
    end

    // Three back-to-back WRITEs: wr_en high on three consecutive cycles.
    for (int k = 0; k < 3; k++) begin
      instr       = {2'b00, FW'(10 + k), FW'(100 + k)};
      instr_valid = 1'b1;
      @(negedge clk);
      chk("b2b_wr_en",   int'(wr_en),   1);
      chk("b2b_wr_addr", int'(wr_addr), 10 + k);
      chk("b2b_wr_data", int'(wr_data), 100 + k);
    end
    instr_valid = 1'b0;
    model_wa    = 12;
    model_wd    = 102;
    @(negedge clk);
    chk("b2b_wr_en_drop", int'(wr_en), 0);

    // READ 3..5 with two stall cycles at address 4.
    send(2'b01, 3, 5);
    run_burst(3, 5, 2);

    // Next instruction accepted one cycle after the final beat.
    send(2'b10, 0, 0);
    chk("go_after_burst", int'(go), 1);
    @(negedge clk);
    chk("go_one_cycle", int'(go), 0);

    // Asynchronous reset mid-burst at address 40.
    rd_ready = 1'b1;
    send(2'b01, 0, 100);
    repeat (40) @(negedge clk);
    chk("pre_reset_rd_addr", int'(rd_addr), 40);
    #2 rst = 1'b1;
    #1;
    chk("arst_rd_en",   int'(rd_en),   0);
    chk("arst_busy",    int'(busy),    0);
    chk("arst_rd_addr", int'(rd_addr), 0);
    chk("arst_rd_last", int'(rd_last), 0);
    chk("arst_wr_addr", int'(wr_addr), 0);
    chk("arst_wr_data", int'(wr_data), 0);
    chk_quiet_strobes("arst");
    model_wa = 0;
    model_wd = 0;
    @(negedge clk);
    rst = 1'b0;
    chk("arst_release_ready", int'(instr_ready), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("arst_no_rd_en", int'(rd_en), 0);
    end

    // Randomized instructions against the transaction model.
    for (int n = 0; n < 200; n++) begin
      rd_ready = $urandom_range(0, 1);
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        chk_quiet_strobes("rand_gap");
        chk("rand_gap_rd_en", int'(rd_en), 0);
      end
      op_i = $urandom_range(0, 3);
      s    = $urandom_range(0, 'h7FFF);
      if (op_i == 1) begin
        if ($urandom_range(0, 4) == 0) begin
          e = (s > 0) ? s - int'($urandom_range(1, 3)) : 0;
          if (e < 0) e = 0;
          if (s == 0) s = 1;
        end else begin
          e = s + int'($urandom_range(0, 6));
          if (e > 'h7FFF) e = 'h7FFF;
        end
      end else begin
        e = $urandom_range(0, 'h7FFF);
      end
      send(2'(op_i), s, e);
      if (op_i == 1 && e >= s) run_burst(s, e, 1);
      else                     check_single(2'(op_i), s, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always reaches a summary line.
  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Parametrised, clocked successor to the combinational micro-instruction decoder. Accepts packed micro-instructions over a valid/ready handshake, then issues registered write strobes, go pulses, and multi-beat read bursts that step one address per beat from a start address to an end address, with downstream back-pressure. Sits between the host instruction FIFO and the memory/accelerator datapath.

## Interface
- FIELD_W, 15, width of the address and data fields.
- INSTR_W, 2+2*FIELD_W (derived, not overridable), width of the instruction word.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- instr  in  INSTR_W  instruction: opcode = instr[INSTR_W-1:INSTR_W-2], field A = instr[2*FIELD_W-1:FIELD_W], field B = instr[FIELD_W-1:0].
- instr_valid  in  1  instr is valid.
- instr_ready  out  1  block accepts instr this cycle.
- wr_en  out  1  one-cycle write strobe.
- wr_addr  out  FIELD_W  write address (field A).
- wr_data  out  FIELD_W  write data (field B).
- rd_en  out  1  read beat valid.
- rd_ready  in  1  downstream accepts the read beat.
- rd_addr  out  FIELD_W  current read address.
- rd_last  out  1  current beat is the final beat of the burst.
- go  out  1  one-cycle go pulse.
- busy  out  1  read burst in progress.
- err  out  1  one-cycle pulse on a rejected instruction.

## Operation
- Opcodes:
  - 00 = WRITE (A = addr, B = data).
  - 01 = READ (A = start, B = end, inclusive).
  - 10 = GO (fields ignored).
  - 11 = reserved.
- Accept condition: instr_valid && instr_ready.
- States: IDLE and BURST. instr_ready = (state == IDLE).
- IDLE, WRITE accepted:
  - Next cycle: wr_en = 1 for one cycle, with wr_addr/wr_data registered from the fields.
  - Stay in IDLE. Back-to-back WRITEs give wr_en on consecutive cycles.
- IDLE, GO accepted: go = 1 for one cycle on the next cycle. Stay in IDLE.
- IDLE, READ accepted with end >= start:
  - Latch start and end; rd_addr <= start; go to BURST.
- IDLE, READ accepted with end < start:
  - err = 1 for one cycle on the next cycle. No read beats. Stay in IDLE.
- IDLE, reserved opcode 11 accepted: err pulse next cycle, otherwise ignored.
- BURST:
  - rd_en = 1 and busy = 1.
  - rd_last = (rd_addr == latched end).
  - When rd_ready && !rd_last: rd_addr increments by 1.
  - When rd_ready && rd_last: return to IDLE; rd_en, busy and rd_last drop next cycle.
  - When rd_ready = 0: rd_addr, rd_en and rd_last hold.
- Arithmetic and widths:
  - rd_addr is FIELD_W bits.
  - End detection is by equality with the latched end, so a burst ending at 2^FIELD_W-1 never wraps.
  - Burst length is end-start+1 beats, from 1 up to 2^FIELD_W.
- Write/read exclusivity: wr_en, go and err are zero in every BURST cycle, because no instruction is accepted there.
- Registered output values: wr_addr/wr_data hold the last WRITE values. rd_addr holds its last value after a burst. Their values are don't-care when the matching strobe is low.
- Reset (any time, including mid-burst): state = IDLE, and all outputs are 0. instr_ready is therefore 1 as soon as rst deasserts. An in-flight burst is abandoned.

## Timing
- Instruction to wr_en/go/err: 1 cycle.
- Instruction to first rd_en: 1 cycle.
- Throughput: one WRITE or GO per cycle. One read beat per cycle when rd_ready = 1.
- Cycle after the last read beat: state is IDLE, so the next instruction can be accepted 1 cycle after the final rd handshake.
- All outputs are registered except instr_ready, which is decoded directly from the state register.
- rd_ready may toggle on any cycle; rd_en never drops before its beat is accepted.

## Test plan
- WRITE 00/addr 0x0012/data 0x7ABC accepted at cycle N -> wr_en = 1 at N+1 only, wr_addr = 0x0012, wr_data = 0x7ABC. Three back-to-back WRITEs give wr_en high for 3 consecutive cycles.
- READ start 3, end 5, rd_ready = 1 -> rd_addr 3, 4, 5 on 3 consecutive cycles. rd_last only on addr 5. instr_ready = 0 for those 3 cycles, then 1.
- READ start 3, end 5, with rd_ready held low for 2 cycles at addr 4 -> addr 4 is held for 3 cycles, rd_en stays high, and there are exactly 3 accepted beats in total.
- READ start 0x7FFE, end 0x7FFF -> 2 beats, rd_last on 0x7FFF, no wrap to 0. READ start 9, end 9 -> 1 beat with rd_last. READ start 5, end 2 -> err pulse, no rd_en.
- GO accepted -> go = 1 for exactly one cycle. Opcode 11 accepted -> err = 1 for one cycle, no other output changes.
- rst asserted asynchronously mid-way through a READ 0 to 100 at addr 40 -> all outputs 0 immediately. After release, instr_ready = 1 and no further rd_en appears.
